strided_wp_ram: RTL and testbench
=================================

Name: strided_wp_ram

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 1024x8 even-address-write RAM.
- Generalised in data width, depth and write stride/phase.
- Adds:
  - a valid/ready request interface with registered responses;
  - a sequential hardware clear engine (on reset and on demand);
  - per-write accept/reject status and a saturating rejected-write counter.
- Sits behind a bus master as local scratch storage where only a programmable address lattice is writable.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- STRIDE_LOG2, 1, number of low address bits checked for write permission; 0 = every address writable.
- WR_PHASE, 0, required value of addr[STRIDE_LOG2-1:0] for a write to be allowed. Ignored when STRIDE_LOG2 = 0.
- CLEAR_ON_RST, 1, 1 = run the clear sweep after reset; 0 = go straight to IDLE with memory contents undefined.
- CNT_W, 8, width of the rejected-write counter.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst, in, 1, reset: synchronous, active-high.
- req_valid, in, 1, request present.
- req_ready, out, 1, block can accept a request this cycle.
- req_wr, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, word address.
- req_wdata, in, DATA_W, write data.
- rsp_valid, out, 1, response strobe, one cycle per accepted request.
- rsp_rdata, out, DATA_W, read data; 0 on write responses.
- rsp_err, out, 1, 1 = write rejected by the stride rule.
- clr_req, in, 1, pulse to start a clear sweep.
- busy, out, 1, clear sweep in progress.
- rej_cnt, out, CNT_W, saturating count of rejected writes.
- rej_clr, in, 1, synchronous clear of rej_cnt.

Behaviour:
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, rej_cnt=0, clear pointer=0.
  - With CLEAR_ON_RST=1: state=CLEAR, busy=1, req_ready=0.
  - With CLEAR_ON_RST=0: state=IDLE, busy=0, req_ready=1.
- State machine, two states:
  - CLEAR:
    - Each cycle writes 0 to mem[ptr], then ptr++.
    - After writing ptr = DEPTH-1, moves to IDLE; the sweep takes exactly DEPTH cycles.
    - req_ready=0, busy=1. clr_req is ignored.
  - IDLE:
    - req_ready=1, busy=0.
    - clr_req=1 -> next state CLEAR with ptr=0.
- rst asserted mid-sweep restarts the sweep from ptr=0; the rst cycle itself counts as no sweep cycle.
- A request is accepted only when req_valid && req_ready; it is sampled at that edge.
- Read: rsp_valid=1 on the next cycle with rsp_rdata=mem[addr] and rsp_err=0.
  - Fixed latency of 1 cycle. No response backpressure.
- Write allowed (STRIDE_LOG2=0, or addr[STRIDE_LOG2-1:0]==WR_PHASE):
  - mem[addr]<=wdata.
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Write rejected:
  - Memory unchanged.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - rej_cnt increments, saturating at 2**CNT_W-1.
- rej_clr and a rejected write in the same cycle: rej_cnt becomes 1. rej_clr alone: rej_cnt becomes 0.
- Back-to-back write then read of the same address: the read returns the newly written data.
- clr_req and an accepted request in the same IDLE cycle:
  - The request completes normally and its response is issued.
  - CLEAR starts the following cycle and zeroes that location too.
- rsp_valid is a single-cycle strobe; it deasserts in any cycle after no accepted request.
- rsp_rdata holds its last value when rsp_valid=0.
- Reads are permitted at every address regardless of stride.

Decomposition:
- Shared package strided_ram_pkg:
  - state enum {ST_IDLE, ST_CLEAR};
  - function wr_allowed(addr, STRIDE_LOG2, WR_PHASE);
  - localparam DEPTH derived from ADDR_W.
- One natural sub-module: ram_sp_core.
  - Plain DEPTH x DATA_W synchronous single-port array with we/addr/wdata/rdata.
  - The top level multiplexes the clear engine and the request path onto it.

Test Plan:
- Reset with CLEAR_ON_RST=1 -> busy=1 and req_ready=0 for exactly 1024 cycles, then req_ready=1.
  - Read addr 0x3FF -> rsp_rdata=0x00.
- Write 0xA5 to addr 0x010 (even) -> next cycle rsp_valid=1, rsp_err=0.
  - Read 0x010 -> 0xA5.
- Write 0x5A to addr 0x011 (odd) -> rsp_err=1, rej_cnt=1.
  - Read 0x011 -> 0x00 (unchanged).
- 260 consecutive odd-address writes with CNT_W=8 -> rej_cnt saturates at 255.
  - rej_clr together with one more odd write -> rej_cnt=1.
- Write 0x77 to 0x020, then in the same cycle as a read of 0x020 pulse clr_req:
  - the read responds 0x77;
  - busy=1 for 1024 cycles;
  - a subsequent read of 0x020 returns 0x00.
- STRIDE_LOG2=2, WR_PHASE=3: write to 0x007 is accepted and write to 0x004 is rejected.
  - rst asserted at sweep cycle 500 -> the sweep restarts and lasts a full 1024 cycles.

Source files
------------

// File: rtl/strided_ram_pkg.sv
// Shared types and helpers for the strided write-protected RAM.
// Defines the FSM state encoding and the write-permission rule.
package strided_ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

  // A write is permitted only on the lattice addr[stride_log2-1:0] == wr_phase.
  function automatic logic wr_allowed(input logic [31:0] addr,
                                      input int          stride_log2,
                                      input int          wr_phase);
    logic [31:0] mask;
    if (stride_log2 == 0) return 1'b1;
    mask = (32'd1 << stride_log2) - 32'd1;
    return (addr & mask) == (32'(wr_phase) & mask);
  endfunction

endpackage

// File: rtl/strided_wp_ram_if.sv
// Request/response bus of the strided write-protected RAM.
// A request transfers on a rising edge where req_valid && req_ready; the
// response is a one-cycle rsp_valid strobe on the following cycle, with no backpressure.
interface strided_wp_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_sp_core.sv
// Plain single-port synchronous RAM, read-first, registered read data.
// No reset on the array or the read register.
module ram_sp_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/strided_wp_ram.sv
// Scratch RAM where only a programmable address lattice is writable, with a
// sequential clear engine, per-write status and a saturating reject counter.
module strided_wp_ram
  import strided_ram_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STRIDE_LOG2  = 1,
  parameter int WR_PHASE     = 0,
  parameter bit CLEAR_ON_RST = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  strided_wp_ram_if.slave  bus,
  input  logic             clr_req,
  output logic             busy,
  output logic [CNT_W-1:0] rej_cnt,
  input  logic             rej_clr,
  output state_t           dbg_state
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  logic              accept;
  logic              allowed;
  logic              rej_event;

  logic              rsp_valid_q;
  logic              rsp_rd_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] rdata_now;
  logic [CNT_W-1:0]  rej_q;

  assign allowed   = wr_allowed(32'(bus.req_addr), STRIDE_LOG2, WR_PHASE);
  assign accept    = bus.req_valid && bus.req_ready && !rst;
  assign rej_event = accept && bus.req_wr && !allowed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    bus.req_ready = 1'b0;
    busy          = 1'b0;
    core_we       = 1'b0;
    core_addr     = bus.req_addr;
    core_wdata    = bus.req_wdata;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        core_we       = accept && bus.req_wr && allowed;
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        busy       = 1'b1;
        core_we    = !rst;
        core_addr  = ptr_q;
        core_wdata = '0;
        ptr_d      = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ram_sp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk   (clk),
    .we    (core_we),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // Read data is only meaningful in the strobe cycle; otherwise show the last response.
  assign rdata_now = rsp_rd_q ? core_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      hold_q      <= '0;
      rej_q       <= '0;
    end else begin
      rsp_valid_q <= accept;
      rsp_rd_q    <= accept && !bus.req_wr;
      rsp_err_q   <= rej_event;
      if (rsp_valid_q) hold_q <= rdata_now;
      if (rej_clr)                     rej_q <= rej_event ? CNT_W'(1) : '0;
      else if (rej_event && rej_q != '1) rej_q <= rej_q + 1'b1;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_valid_q ? rdata_now : hold_q;
  assign rej_cnt       = rej_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_strided_wp_ram.sv
// Directed bench for strided_wp_ram: default lattice (stride 2, phase 0) and a
// second instance with stride 4, phase 3.
module tb_strided_wp_ram;
  import strided_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       clr_req, clr_req2, rej_clr, rej_clr2;
  logic       busy, busy2;
  logic [7:0] rej_cnt, rej_cnt2;
  state_t     dbg_state, dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  strided_wp_ram_if #(.DATA_W(8), .ADDR_W(10)) bus  ();
  strided_wp_ram_if #(.DATA_W(8), .ADDR_W(10)) bus2 ();

  strided_wp_ram dut (
    .clk (clk), .rst (rst), .bus (bus), .clr_req (clr_req), .busy (busy),
    .rej_cnt (rej_cnt), .rej_clr (rej_clr), .dbg_state (dbg_state)
  );

  strided_wp_ram #(.STRIDE_LOG2(2), .WR_PHASE(3)) dut2 (
    .clk (clk), .rst (rst2), .bus (bus2), .clr_req (clr_req2), .busy (busy2),
    .rej_cnt (rej_cnt2), .rej_clr (rej_clr2), .dbg_state (dbg_state2)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic do_req(input logic wr, input logic [9:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rdata, input logic exp_err, input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    exp_q.push_back(exp_rdata);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_err"},   32'(bus.rsp_err),   32'(exp_err));
    check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
  endtask

  task automatic do_req2(input logic wr, input logic [9:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata, input logic exp_err, input string tag);
    check({tag, "_ready"}, 32'(bus2.req_ready), 32'd1);
    bus2.req_valid = 1'b1;
    bus2.req_wr    = wr;
    bus2.req_addr  = addr;
    bus2.req_wdata = wdata;
    exp_q.push_back(exp_rdata);
    @(posedge clk);
    @(negedge clk);
    bus2.req_valid = 1'b0;
    bus2.req_wr    = 1'b0;
    check({tag, "_valid"}, 32'(bus2.rsp_valid), 32'd1);
    check({tag, "_err"},   32'(bus2.rsp_err),   32'(exp_err));
    check({tag, "_rdata"}, 32'(bus2.rsp_rdata), 32'(exp_q.pop_front()));
  endtask

  // Counts consecutive negedges with busy high, starting at the current one.
  task automatic count_busy(input logic which, output int n);
    n = 0;
    while ((which ? busy2 : busy) && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    clr_req = 1'b0; clr_req2 = 1'b0; rej_clr = 1'b0; rej_clr2 = 1'b0;
    bus.req_valid = 1'b0;  bus.req_wr = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
    bus2.req_valid = 1'b0; bus2.req_wr = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_rej_cnt",   32'(rej_cnt),       32'd0);
    check("rst_busy",      32'(busy),          32'd1);
    check("rst_ready",     32'(bus.req_ready), 32'd0);
    check("rst_state",     32'(dbg_state),     32'(ST_CLEAR));
    count_busy(1'b0, n);
    check("init_sweep_len", 32'(n), 32'd1024);
    check("init_ready", 32'(bus.req_ready), 32'd1);

    do_req(1'b0, 10'h3FF, 8'h00, 8'h00, 1'b0, "rd_3ff");
    do_req(1'b1, 10'h010, 8'hA5, 8'h00, 1'b0, "wr_010");
    do_req(1'b1, 10'h011, 8'h5A, 8'h00, 1'b1, "wr_011_rej");
    check("rej_cnt_1", 32'(rej_cnt), 32'd1);
    do_req(1'b0, 10'h011, 8'h00, 8'h00, 1'b0, "rd_011");
    do_req(1'b0, 10'h010, 8'h00, 8'hA5, 1'b0, "rd_010");
    @(negedge clk);
    check("idle_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_hold",  32'(bus.rsp_rdata), 32'hA5);

    for (int i = 0; i < 260; i++)
      do_req(1'b1, 10'((2 * i + 1) % 1024), 8'(i), 8'h00, 1'b1, "odd_wr");
    check("rej_cnt_sat", 32'(rej_cnt), 32'd255);
    rej_clr = 1'b1;
    do_req(1'b1, 10'h101, 8'h11, 8'h00, 1'b1, "clr_and_rej");
    rej_clr = 1'b0;
    check("rej_cnt_clr_rej", 32'(rej_cnt), 32'd1);
    rej_clr = 1'b1;
    @(negedge clk);
    rej_clr = 1'b0;
    check("rej_cnt_clr", 32'(rej_cnt), 32'd0);

    do_req(1'b1, 10'h020, 8'h77, 8'h00, 1'b0, "wr_020");
    clr_req = 1'b1;
    do_req(1'b0, 10'h020, 8'h00, 8'h77, 1'b0, "rd_020_clr");
    clr_req = 1'b0;
    count_busy(1'b0, n);
    check("clr_sweep_len", 32'(n), 32'd1024);
    do_req(1'b0, 10'h020, 8'h00, 8'h00, 1'b0, "rd_020_after");
    do_req(1'b0, 10'h010, 8'h00, 8'h00, 1'b0, "rd_010_after");

    do_req2(1'b1, 10'h007, 8'h3C, 8'h00, 1'b0, "s4_wr_007");
    do_req2(1'b1, 10'h004, 8'hC3, 8'h00, 1'b1, "s4_wr_004_rej");
    do_req2(1'b0, 10'h007, 8'h00, 8'h3C, 1'b0, "s4_rd_007");
    do_req2(1'b0, 10'h004, 8'h00, 8'h00, 1'b0, "s4_rd_004");
    check("s4_rej_cnt", 32'(rej_cnt2), 32'd1);

    clr_req2 = 1'b1;
    @(negedge clk);
    clr_req2 = 1'b0;
    for (int i = 0; i < 500; i++) @(negedge clk);
    check("s4_mid_busy", 32'(busy2), 32'd1);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    check("s4_rst_rej_cnt", 32'(rej_cnt2), 32'd0);
    count_busy(1'b1, n);
    check("s4_restart_len", 32'(n), 32'd1024);
    check("s4_ready_after", 32'(bus2.req_ready), 32'd1);
    do_req2(1'b0, 10'h007, 8'h00, 8'h00, 1'b0, "s4_rd_007_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
